// File: rtl/div_share_arbiter.sv
// Purpose : shares one iterative divider between two request lanes (round-robin),
//           resolving divide-by-zero / signed overflow locally and honouring per-lane kill.
// Latency : accept T -> divider start T+1 -> result one cycle after div_done; fast path T+1.
// Backpr. : one op in flight; reqN_ready only in IDLE for the granted lane; responses
//           are never backpressured (one-cycle respN_valid pulse).
// Ports   : reqN_* / killN / respN_* per lane (N=0,1); div_* drive/observe the divider;
//           busy high whenever the controller is not IDLE.
module div_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            kill0,
  output logic            resp0_valid,
  output logic [XLEN-1:0] resp0_result,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic            kill1,
  output logic            resp1_valid,
  output logic [XLEN-1:0] resp1_result,
  output logic            div_md_type,
  output logic [OP_W-1:0] div_op,
  output logic [XLEN-1:0] div_in1,
  output logic [XLEN-1:0] div_in2,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic            rr_ptr, owner, killed;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;

  logic            elig0, elig1, grant_vld, grant_lane;
  logic [OP_W-1:0] sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            is_rem, is_uns, b_zero, sgn_ovf, fast_hit;
  logic [XLEN-1:0] fast_res;
  logic            kill_owner;

  // Arbitration: a lane being killed this cycle is not eligible.
  assign elig0      = req0_valid && !kill0;
  assign elig1      = req1_valid && !kill1;
  assign grant_vld  = (state == IDLE) && (elig0 || elig1) && !reset;
  assign grant_lane = (elig0 && elig1) ? rr_ptr : elig1;

  assign sel_op = grant_lane ? req1_op : req0_op;
  assign sel_a  = grant_lane ? req1_a  : req0_a;
  assign sel_b  = grant_lane ? req1_b  : req0_b;

  // op[1] selects remainder, op[0] selects unsigned.
  assign is_rem  = sel_op[1];
  assign is_uns  = sel_op[0];
  assign b_zero  = (sel_b == '0);
  assign sgn_ovf = !is_uns && (sel_a == MIN_INT) && (sel_b == '1);
  assign fast_hit = b_zero || sgn_ovf;

  always_comb begin
    fast_res = '0;
    if (b_zero)
      fast_res = is_rem ? sel_a : '1;
    else if (sgn_ovf)
      fast_res = is_rem ? '0 : MIN_INT;
  end

  assign kill_owner = owner ? kill1 : kill0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    resp0_result = '0;
    resp1_result = '0;
    div_md_type  = 1'b0;
    div_op       = '0;
    div_in1      = '0;
    div_in2      = '0;
    busy         = (state != IDLE);

    if (state != IDLE) begin
      div_op  = op_q;
      div_in1 = a_q;
      div_in2 = b_q;
    end

    case (state)
      IDLE: begin
        req0_ready = grant_vld && !grant_lane;
        req1_ready = grant_vld &&  grant_lane;
        if (grant_vld)
          state_nxt = fast_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        div_md_type = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // A kill landing on the done cycle still discards the result.
        if (div_done)
          state_nxt = (killed || kill_owner) ? IDLE : RESP;
      end
      RESP: begin
        // Owner kill in RESP just suppresses the pulse.
        resp0_valid  = !owner && !kill0;
        resp1_valid  =  owner && !kill1;
        resp0_result = resp0_valid ? result_q : '0;
        resp1_result = resp1_valid ? result_q : '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      killed   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (grant_vld) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        owner  <= grant_lane;
        rr_ptr <= !grant_lane;
        killed <= 1'b0;
        if (fast_hit)
          result_q <= fast_res;
      end
      if ((state == ISSUE || state == WAIT) && kill_owner)
        killed <= 1'b1;
      if (state == WAIT && div_done)
        result_q <= div_result;
    end
  end

endmodule
